// File: rtl/uart_test_pkg.sv
// Shared types and defaults for the UART receive sequence checker and
// related board-level test blocks.
package uart_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;

    localparam int unsigned DEF_MSG_DELAY    = 100_000_000;
    localparam int unsigned DEF_BYTE_TIMEOUT = 5_000_000;
    localparam logic [7:0]  DEF_SEED         = 8'h41;

    // Bits needed for a counter that runs 0..max_val-1 (never less than 1).
    function automatic int unsigned cnt_bits(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-high reset.
// Output follows the input with two cycles of latency.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_seq_checker.sv
// Arms uart_rx, collects MSG_LEN words per message and checks them against an
// incrementing pattern, counting messages and errors (mismatches and timeouts).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | stopped, waiting for the synchronized run switch
// ARM      | one cycle: clear word index and word timer, raise rx_trigger
// WAIT     | receiving; each word is either accepted or timed out
// DONE     | one cycle: count message, publish pass, clear message error
// PAUSE    | idle gap of MSG_DELAY cycles before the next message
module uart_rx_seq_checker
    import uart_test_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH   = 8,
    parameter int unsigned            MSG_LEN      = 4,
    parameter int unsigned            MSG_DELAY    = DEF_MSG_DELAY,
    parameter int unsigned            BYTE_TIMEOUT = DEF_BYTE_TIMEOUT,
    parameter logic [DATA_WIDTH-1:0]  SEED         = DATA_WIDTH'(DEF_SEED),
    parameter int unsigned            CNT_WIDTH    = 16
) (
    input  logic                  clk_50M,
    input  logic                  reset,
    input  logic                  run_test_raw,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_trigger,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  pass,
    output logic                  fail,
    output logic [CNT_WIDTH-1:0]  msg_count,
    output logic [CNT_WIDTH-1:0]  err_count
);

    localparam int unsigned TMR_W = cnt_bits(BYTE_TIMEOUT);
    localparam int unsigned DLY_W = cnt_bits(MSG_DELAY);

    localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(BYTE_TIMEOUT - 1);
    localparam logic [DLY_W-1:0]     DLY_LAST = DLY_W'(MSG_DELAY - 1);
    localparam logic [7:0]           IDX_LAST = 8'(MSG_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    state_t                state;
    state_t                next_state;
    logic                  run_test;
    logic [TMR_W-1:0]      timer;
    logic [DLY_W-1:0]      delay_cnt;
    logic [7:0]            word_idx;
    logic [DATA_WIDTH-1:0] expected;
    logic                  msg_err;
    logic                  word_accept;
    logic                  word_timeout;
    logic                  word_bad;

    sync_2ff u_run_sync (
        .clk   (clk_50M),
        .reset (reset),
        .d     (run_test_raw),
        .q     (run_test)
    );

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // rx_valid wins over a timeout landing on the same cycle.
    always_comb begin
        next_state   = state;
        word_accept  = 1'b0;
        word_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run_test) begin
                    next_state = ST_ARM;
                end
            end
            ST_ARM: begin
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (rx_valid) begin
                    word_accept = 1'b1;
                end else if (timer == TMR_LAST) begin
                    word_timeout = 1'b1;
                end
                if ((word_accept || word_timeout) && (word_idx == IDX_LAST)) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (delay_cnt == DLY_LAST) begin
                    next_state = run_test ? ST_ARM : ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign word_bad = word_timeout || (word_accept && (rx_data != expected));
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            rx_trigger <= 1'b0;
            data_out   <= '0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            msg_count  <= '0;
            err_count  <= '0;
            expected   <= SEED;
            word_idx   <= '0;
            timer      <= '0;
            delay_cnt  <= '0;
            msg_err    <= 1'b0;
        end else begin
            // Registered so the trigger is high exactly while in WAIT.
            rx_trigger <= (next_state == ST_WAIT);

            if (state == ST_ARM) begin
                word_idx <= '0;
                timer    <= '0;
            end else if (state == ST_WAIT) begin
                if (word_accept || word_timeout) begin
                    timer    <= '0;
                    word_idx <= word_idx + 8'd1;
                    expected <= expected + DATA_WIDTH'(1);
                end else begin
                    timer <= timer + TMR_W'(1);
                end
            end

            if (word_accept) begin
                data_out <= rx_data;
            end

            if (word_bad) begin
                fail    <= 1'b1;
                msg_err <= 1'b1;
                if (err_count != CNT_MAX) begin
                    err_count <= err_count + CNT_WIDTH'(1);
                end
            end

            if (state == ST_DONE) begin
                pass    <= ~msg_err;
                msg_err <= 1'b0;
                if (msg_count != CNT_MAX) begin
                    msg_count <= msg_count + CNT_WIDTH'(1);
                end
            end

            if (state == ST_PAUSE) begin
                delay_cnt <= (delay_cnt == DLY_LAST) ? '0 : delay_cnt + DLY_W'(1);
            end
        end
    end

endmodule
